// File: rtl/univ_shift_register.sv
// univ_shift_register
//   Operand register with parallel load and multi-step shift/rotate commands.
//   One start strobe (sampled in IDLE with ena=1) runs either a load, a hold,
//   or count steps of SHL/SHR/ROL/ROR/ASR. A two-state FSM (IDLE, SHIFT)
//   sequences the steps and drives the busy/done handshake.
//   Optional feature macro: USR_PARITY_EN adds registered even-parity output par.
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   ena    in   global enable; 0 freezes r, sout, FSM and step counter
//   start  in   command strobe
//   mode   in   000 hold, 001 load, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR, 111 hold
//   count  in   number of shift steps (ignored for load/hold)
//   sin    in   serial input for SHL (into LSB) and SHR (into MSB), sampled per step
//   data   in   parallel load data
//   r      out  register contents
//   sout   out  bit shifted/rotated out by the most recent step
//   busy   out  multi-step command in progress
//   done   out  one-cycle completion pulse
//   par    out  ^r, registered (only with USR_PARITY_EN)
module univ_shift_register #(
   parameter int                WIDTH     = 8,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0,
   localparam int               CW        = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [CW-1:0]    count,
   input  logic             sin,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] r,
   output logic             sout,
   output logic             busy,
   output logic             done
`ifdef USR_PARITY_EN
   ,
   output logic             par
`endif
);

   typedef enum logic {IDLE, SHIFT} state_t;

   localparam logic [2:0] M_LOAD = 3'b001;
   localparam logic [2:0] M_SHL  = 3'b010;
   localparam logic [2:0] M_SHR  = 3'b011;
   localparam logic [2:0] M_ROL  = 3'b100;
   localparam logic [2:0] M_ROR  = 3'b101;
   localparam logic [2:0] M_ASR  = 3'b110;

   state_t           st, st_nxt;
   logic [CW-1:0]    rem, rem_nxt;
   logic [2:0]       mode_q, mode_nxt;
   logic [WIDTH-1:0] r_nxt;
   logic             sout_nxt, done_nxt;
   logic             is_shift;

   // One step applied to v; result is {bit_out, new_value}.
   function automatic logic [WIDTH:0] step_f(input logic [2:0] m,
                                             input logic [WIDTH-1:0] v,
                                             input logic s);
      case (m)
         M_SHL:   step_f = {v[WIDTH-1], v[WIDTH-2:0], s};
         M_SHR:   step_f = {v[0], s, v[WIDTH-1:1]};
         M_ROL:   step_f = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
         M_ROR:   step_f = {v[0], v[0], v[WIDTH-1:1]};
         M_ASR:   step_f = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
         default: step_f = {1'b0, v};
      endcase
   endfunction

   assign is_shift = (mode >= M_SHL) && (mode <= M_ASR);

   always_comb begin
      st_nxt   = st;
      rem_nxt  = rem;
      mode_nxt = mode_q;
      r_nxt    = r;
      sout_nxt = sout;
      done_nxt = 1'b0;
      if (ena) begin
         case (st)
            IDLE: begin
               if (start) begin
                  mode_nxt = mode;
                  if (mode == M_LOAD) begin
                     r_nxt    = data;
                     done_nxt = 1'b1;
                  end else if (is_shift && count != '0) begin
                     // first step happens on the start edge itself
                     {sout_nxt, r_nxt} = step_f(mode, r, sin);
                     if (count == CW'(1)) begin
                        done_nxt = 1'b1;
                     end else begin
                        st_nxt  = SHIFT;
                        rem_nxt = count - 1'b1;
                     end
                  end else begin
                     done_nxt = 1'b1;   // hold, reserved, or zero-step shift
                  end
               end
            end
            SHIFT: begin
               {sout_nxt, r_nxt} = step_f(mode_q, r, sin);
               rem_nxt = rem - 1'b1;
               if (rem == CW'(1)) begin
                  st_nxt   = IDLE;
                  done_nxt = 1'b1;
               end
            end
            default: st_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st     <= IDLE;
         rem    <= '0;
         mode_q <= '0;
         r      <= RESET_VAL;
         sout   <= 1'b0;
         done   <= 1'b0;
      end else begin
         st     <= st_nxt;
         rem    <= rem_nxt;
         mode_q <= mode_nxt;
         r      <= r_nxt;
         sout   <= sout_nxt;
         done   <= done_nxt;
      end
   end

   assign busy = (st == SHIFT);

`ifdef USR_PARITY_EN
   // tracks r_nxt so parity always matches the visible register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) par <= ^RESET_VAL;
      else        par <= ^r_nxt;
   end
`endif

endmodule

// File: tb/tb_univ_shift_register.sv
// tb_univ_shift_register
//   Directed bench for univ_shift_register (WIDTH=8, RESET_VAL=0).
//   Inputs change 1 ns after a rising edge; outputs are checked there too.
module tb_univ_shift_register;
   localparam int W  = 8;
   localparam int CW = $clog2(W+1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ena = 1'b1;
   logic          start = 1'b0;
   logic [2:0]    mode = 3'b000;
   logic [CW-1:0] count = '0;
   logic          sin = 1'b0;
   logic [W-1:0]  data = '0;
   logic [W-1:0]  r;
   logic          sout, busy, done;
`ifdef USR_PARITY_EN
   logic          par;
`endif

   int total = 0;
   int bad   = 0;

   univ_shift_register #(.WIDTH(W), .RESET_VAL('0)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .mode(mode),
      .count(count), .sin(sin), .data(data), .r(r), .sout(sout),
      .busy(busy), .done(done)
`ifdef USR_PARITY_EN
      , .par(par)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // issue one command: start high across exactly one rising edge
   task automatic cmd(input logic [2:0] m, input int n, input logic s, input logic [W-1:0] d);
      mode  = m;
      count = CW'(n);
      sin   = s;
      data  = d;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      logic saw_done;
      // reset state
      #3;
      chk("rst_r", r, 0);
      chk("rst_sout", sout, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // 1. reset aborts a SHIFT command mid-flight
      cmd(3'b001, 0, 1'b0, 8'hA5);
      tick();
      cmd(3'b010, 5, 1'b1, 8'h00);          // step 1 -> 4B
      tick();                                // step 2 -> 97
      chk("t1_mid_r", r, 8'h97);
      chk("t1_mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("t1_rst_r", r, 8'h00);
      chk("t1_rst_busy", busy, 0);
      chk("t1_rst_sout", sout, 0);
      #2;
      rst_n = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done) saw_done = 1'b1;
      end
      chk("t1_no_done", saw_done, 0);

      // 2. load A5, then SHL 3 with sin=1
      cmd(3'b001, 0, 1'b0, 8'hA5);
      chk("t2_load_r", r, 8'hA5);
      chk("t2_load_done", done, 1);
      chk("t2_load_busy", busy, 0);
      tick();
      chk("t2_done_pulse", done, 0);
      cmd(3'b010, 3, 1'b1, 8'h00);
      chk("t2_s1_r", r, 8'h4B);
      chk("t2_s1_busy", busy, 1);
      chk("t2_s1_done", done, 0);
      tick();
      chk("t2_s2_r", r, 8'h97);
      chk("t2_s2_sout", sout, 0);
      tick();
      chk("t2_r", r, 8'h2F);
      chk("t2_sout", sout, 1);
      chk("t2_done", done, 1);
      chk("t2_busy", busy, 0);
      tick();

      // 3. ROR 1 from 81, then ASR 2 issued on the done cycle
      cmd(3'b001, 0, 1'b0, 8'h81);
      tick();
      cmd(3'b101, 1, 1'b0, 8'h00);
      chk("t3_ror_r", r, 8'hC0);
      chk("t3_ror_sout", sout, 1);
      chk("t3_ror_done", done, 1);
      chk("t3_ror_busy", busy, 0);
      cmd(3'b110, 2, 1'b0, 8'h00);
      chk("t3_asr1_r", r, 8'hE0);
      tick();
      chk("t3_asr_r", r, 8'hF0);
      chk("t3_asr_sout", sout, 0);
      chk("t3_asr_done", done, 1);
      tick();

      // 4. ROL 4 from 3C with a 2-cycle stall and an ignored start
      cmd(3'b001, 0, 1'b0, 8'h3C);
      tick();
      cmd(3'b100, 4, 1'b0, 8'h00);          // edge 1 -> 78
      mode  = 3'b001;                        // load 00 attempt while busy
      count = '0;
      data  = 8'h00;
      start = 1'b1;
      tick();                                // edge 2 -> F0
      start = 1'b0;
      chk("t4_ign_r", r, 8'hF0);
      chk("t4_ign_busy", busy, 1);
      ena = 1'b0;
      tick();                                // edge 3 stalled
      tick();                                // edge 4 stalled
      chk("t4_stall_r", r, 8'hF0);
      chk("t4_stall_done", done, 0);
      chk("t4_stall_busy", busy, 1);
      ena = 1'b1;
      tick();                                // edge 5 -> E1
      chk("t4_s3_r", r, 8'hE1);
      chk("t4_s3_done", done, 0);
      tick();                                // edge 6 -> C3
      chk("t4_r", r, 8'hC3);
      chk("t4_sout", sout, 1);
      chk("t4_done", done, 1);
      chk("t4_busy", busy, 0);
      tick();
      chk("t4_after_r", r, 8'hC3);
      chk("t4_after_done", done, 0);

      // 5. SHR 0 is a no-op; SHL 9 with sin=0 clears FF
      cmd(3'b011, 0, 1'b1, 8'h00);
      chk("t5_n0_r", r, 8'hC3);
      chk("t5_n0_sout", sout, 1);
      chk("t5_n0_done", done, 1);
      chk("t5_n0_busy", busy, 0);
      tick();
      cmd(3'b001, 0, 1'b0, 8'hFF);
      tick();
      cmd(3'b010, 9, 1'b0, 8'h00);
      for (int i = 0; i < 7; i++) tick();
      chk("t5_s8_r", r, 8'h00);
      chk("t5_s8_busy", busy, 1);
      chk("t5_s8_sout", sout, 1);
      tick();
      chk("t5_r", r, 8'h00);
      chk("t5_sout", sout, 0);
      chk("t5_done", done, 1);
      tick();

`ifdef USR_PARITY_EN
      // 6. parity follows r on the same edge
      cmd(3'b001, 0, 1'b0, 8'h07);
      chk("t6_par07", par, 1);
      cmd(3'b010, 1, 1'b0, 8'h00);
      chk("t6_r0e", r, 8'h0E);
      chk("t6_par0e", par, 1);
      cmd(3'b001, 0, 1'b0, 8'h03);
      chk("t6_par03", par, 0);
      tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected finish");
      $fatal(1);
   end
endmodule
